// File: rtl/bp_fe_bht_sat_if.sv
// bp_fe_bht_sat_if: lookup/update port bundle between the FE fetch logic and the branch history table
interface bp_fe_bht_sat_if #(
  parameter int vaddr_width_p = 39,
  parameter int ghist_width_p = 2,
  parameter int bht_idx_width_p = 9,
  parameter int bht_offset_width_p = 1,
  parameter int ctr_width_p = 3
);
  localparam int row_width_lp = ctr_width_p * (1 << bht_offset_width_p);
  logic w_v_i;
  logic [bht_idx_width_p-1:0] w_idx_i;
  logic [bht_offset_width_p-1:0] w_offset_i;
  logic [row_width_lp-1:0] w_val_i;
  logic w_taken_i;
  logic w_force_i;
  logic w_yumi_o;
  logic r_v_i;
  logic [vaddr_width_p-1:0] r_addr_i;
  logic [ghist_width_p-1:0] r_ghist_i;
  logic pred_v_o;
  logic [row_width_lp-1:0] val_o;
  logic pred_o;
  logic conf_o;
  logic [bht_idx_width_p-1:0] idx_o;
  logic [bht_offset_width_p-1:0] offset_o;
  modport master (
    output w_v_i, w_idx_i, w_offset_i, w_val_i, w_taken_i, w_force_i, r_v_i, r_addr_i, r_ghist_i,
    input w_yumi_o, pred_v_o, val_o, pred_o, conf_o, idx_o, offset_o
  );
  modport slave (
    input w_v_i, w_idx_i, w_offset_i, w_val_i, w_taken_i, w_force_i, r_v_i, r_addr_i, r_ghist_i,
    output w_yumi_o, pred_v_o, val_o, pred_o, conf_o, idx_o, offset_o
  );
endinterface

// File: rtl/bp_fe_bht_sat.sv
// bp_fe_bht_sat: saturating-counter branch history table with runtime bimodal/gshare/gselect indexing
module bp_fe_bht_sat #(
  parameter int vaddr_width_p = 39,
  parameter int ghist_width_p = 2,
  parameter int bht_idx_width_p = 9,
  parameter int bht_offset_width_p = 1,
  parameter int bht_row_els_p = 1 << bht_offset_width_p,
  parameter int ctr_width_p = 3,
  parameter int fetch_sel_p = 1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic flush_i,
  input  logic [1:0] mode_i,
  output logic init_done_o,
  bp_fe_bht_sat_if.slave bht
);
  localparam int row_width_lp = ctr_width_p * bht_row_els_p;
  localparam int rows_lp = 1 << bht_idx_width_p;
  localparam int addr_lo_lp = 1 + fetch_sel_p;
  localparam int off_lo_lp = addr_lo_lp + bht_idx_width_p;
  localparam logic [ctr_width_p-1:0] ctr_max_lp = '1;
  localparam logic [ctr_width_p-1:0] weak_nt_lp = ctr_width_p'((1 << (ctr_width_p - 1)) - 1);
  localparam logic [row_width_lp-1:0] clr_row_lp = {bht_row_els_p{weak_nt_lp}};
  localparam logic [bht_idx_width_p-1:0] sel_mask_lp =
    bht_idx_width_p'((64'(1) << (bht_idx_width_p - ghist_width_p)) - 64'(1));

  typedef enum logic [1:0] {RESET, CLEAR, RUN} state_e;
  state_e state_r, state_n;
  logic [bht_idx_width_p-1:0] init_cnt_r;
  logic [row_width_lp-1:0] mem_r [rows_lp];
  logic [bht_idx_width_p-1:0] a, h, r_idx;
  logic [bht_offset_width_p-1:0] r_off;
  logic [ctr_width_p-1:0] w_ctr, rd_ctr;
  logic [row_width_lp-1:0] w_row, rd_row;
  logic run, collide, rd_ok, wr_ok;
  logic unused;

  assign unused = ^{bht.r_addr_i[vaddr_width_p-1:off_lo_lp+bht_offset_width_p], bht.r_addr_i[0]};

  always_comb begin
    a = bht.r_addr_i[addr_lo_lp +: bht_idx_width_p];
    h = bht_idx_width_p'({bht.r_ghist_i, bht.r_addr_i[1 +: fetch_sel_p]});
    r_idx = mode_i == 2'd1 ? a ^ h
          : mode_i == 2'd2 ? (a & sel_mask_lp) | (bht_idx_width_p'(bht.r_ghist_i) << (bht_idx_width_p - ghist_width_p))
          : a;
    r_off = bht.r_addr_i[off_lo_lp +: bht_offset_width_p];
    rd_row = mem_r[r_idx];
    rd_ctr = rd_row[r_off*ctr_width_p +: ctr_width_p];
    w_ctr = bht.w_val_i[bht.w_offset_i*ctr_width_p +: ctr_width_p];
    w_row = bht.w_val_i;
    w_row[bht.w_offset_i*ctr_width_p +: ctr_width_p] = bht.w_taken_i
      ? (w_ctr == ctr_max_lp ? w_ctr : w_ctr + 1'b1)
      : (w_ctr == '0 ? w_ctr : w_ctr - 1'b1);
  end

  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      state_r <= RESET;
      init_cnt_r <= '0;
    end else begin
      state_r <= state_n;
      init_cnt_r <= (state_r == CLEAR && !flush_i) ? init_cnt_r + 1'b1 : '0;
    end

  always_comb begin
    state_n = state_r == RESET ? CLEAR
            : state_r == CLEAR ? ((init_cnt_r == '1 && !flush_i) ? RUN : CLEAR)
            : flush_i ? CLEAR : RUN;
  end

  // a same-row read/write pair lets exactly one side through, chosen by w_force_i
  always_comb begin
    run = state_r == RUN;
    collide = bht.r_v_i & bht.w_v_i & (r_idx == bht.w_idx_i);
    rd_ok = run & bht.r_v_i & ~(collide & bht.w_force_i);
    wr_ok = run & bht.w_v_i & ~(collide & ~bht.w_force_i);
    init_done_o = run;
    bht.w_yumi_o = wr_ok;
  end

  always_ff @(posedge clk_i)
    if (state_r == CLEAR) mem_r[init_cnt_r] <= clr_row_lp;
    else if (wr_ok) mem_r[bht.w_idx_i] <= w_row;

  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      bht.pred_v_o <= 1'b0;
      bht.val_o <= '0;
      bht.pred_o <= 1'b0;
      bht.conf_o <= 1'b0;
      bht.idx_o <= '0;
      bht.offset_o <= '0;
    end else begin
      bht.pred_v_o <= rd_ok;
      if (rd_ok) begin
        bht.val_o <= rd_row;
        bht.pred_o <= rd_ctr[ctr_width_p-1];
        bht.conf_o <= &rd_ctr | ~|rd_ctr;
        bht.idx_o <= r_idx;
        bht.offset_o <= r_off;
      end
    end
endmodule

// File: tb/tb_bp_fe_bht_sat.sv
// tb_bp_fe_bht_sat: directed and randomized checks of the BHT against a per-counter integer model
module tb_bp_fe_bht_sat;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic [1:0] mode = 2'd0;
  logic init_done;
  int pass_cnt = 0;
  int total_cnt = 0;
  int mdl [512][2];
  logic [5:0] e_val;
  logic e_pred, e_conf, e_off;
  logic [8:0] e_idx;

  bp_fe_bht_sat_if bus ();
  bp_fe_bht_sat dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .mode_i(mode),
    .init_done_o(init_done), .bht(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  function automatic logic [8:0] exp_idx(logic [38:0] addr, logic [1:0] gh, logic [1:0] md);
    int a, h;
    a = int'(addr[31:0] >> 2) % 512;
    h = (int'(gh) * 2 + int'(addr[1])) % 512;
    return 9'(md == 2'd1 ? a ^ h : md == 2'd2 ? int'(gh) * 128 + a % 128 : a);
  endfunction

  function automatic logic [5:0] row_of(int i);
    return 6'(mdl[i][1] * 8 + mdl[i][0]);
  endfunction

  task automatic clear_model();
    foreach (mdl[i, j]) mdl[i][j] = 3;
  endtask

  task automatic upd(int i, int o, logic tk);
    mdl[i][o] = tk ? (mdl[i][o] == 7 ? 7 : mdl[i][o] + 1) : (mdl[i][o] == 0 ? 0 : mdl[i][o] - 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.r_v_i = 1'b0;
    bus.w_v_i = 1'b0;
    bus.w_taken_i = 1'b0;
    bus.w_force_i = 1'b0;
    flush = 1'b0;
  endtask

  task automatic set_read(logic [38:0] addr, logic [1:0] gh, logic [1:0] md);
    bus.r_v_i = 1'b1;
    bus.r_addr_i = addr;
    bus.r_ghist_i = gh;
    mode = md;
  endtask

  task automatic set_write(int idx, int off, logic tk, logic fc);
    bus.w_v_i = 1'b1;
    bus.w_idx_i = 9'(idx);
    bus.w_offset_i = 1'(off);
    bus.w_val_i = row_of(idx);
    bus.w_taken_i = tk;
    bus.w_force_i = fc;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    idle();
    bus.w_v_i = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({init_done, bus.pred_v_o, bus.w_yumi_o, bus.val_o, bus.pred_o, bus.conf_o, bus.idx_o, bus.offset_o} !== '0)
      $display("FAIL reset_state: got %h want 0",
               {init_done, bus.pred_v_o, bus.w_yumi_o, bus.val_o, bus.pred_o, bus.conf_o, bus.idx_o, bus.offset_o});
    else pass_cnt++;
    idle();
    reset_n = 1'b1;
    wait_init(n);
    total_cnt++;
    if (n !== 513) $display("FAIL reset_init_cycles: got %0d want 513", n);
    else pass_cnt++;
    clear_model();
  endtask

  task automatic test_init_read();
    logic [38:0] addr;
    for (int i = 0; i < 512; i++) begin
      addr = {7'($urandom), 20'($urandom), 1'($urandom), 9'(i), 2'($urandom)};
      set_read(addr, 2'($urandom), 2'd0);
      tick();
      idle();
      total_cnt++;
      if ({bus.pred_v_o, bus.val_o, bus.pred_o, bus.conf_o, bus.idx_o, bus.offset_o} !==
          {1'b1, 6'o33, 1'b0, 1'b0, 9'(i), addr[11]})
        $display("FAIL init_row_%0d: got %h want %h", i,
                 {bus.pred_v_o, bus.val_o, bus.pred_o, bus.conf_o, bus.idx_o, bus.offset_o},
                 {1'b1, 6'o33, 1'b0, 1'b0, 9'(i), addr[11]});
      else pass_cnt++;
    end
  endtask

  task automatic test_modes();
    int want [4] = '{141, 139, 397, 141};
    for (int m = 0; m < 4; m++) begin
      set_read(39'h1234, 2'b11, 2'(m));
      tick();
      idle();
      total_cnt++;
      if ({bus.pred_v_o, bus.idx_o, bus.offset_o} !== {1'b1, 9'(want[m]), 1'b0})
        $display("FAIL mode_%0d_index: got idx %0d off %0d v %0d want idx %0d off 0 v 1",
                 m, bus.idx_o, bus.offset_o, bus.pred_v_o, want[m]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    int want [5] = '{4, 5, 6, 7, 7};
    for (int k = 0; k < 5; k++) begin
      set_write(10, 1, 1'b1, 1'b0);
      #1;
      total_cnt++;
      if (bus.w_yumi_o !== 1'b1) $display("FAIL sat_yumi_%0d: got %b want 1", k, bus.w_yumi_o);
      else pass_cnt++;
      tick();
      idle();
      upd(10, 1, 1'b1);
      set_read(39'h800 | 39'(10 << 2), 2'd0, 2'd0);
      tick();
      idle();
      total_cnt++;
      if ({bus.val_o, bus.pred_o, bus.conf_o} !== {3'(want[k]), 3'b011, 1'b1, 1'(want[k] == 7)})
        $display("FAIL sat_step_%0d: got %h want %h", k, {bus.val_o, bus.pred_o, bus.conf_o},
                 {3'(want[k]), 3'b011, 1'b1, 1'(want[k] == 7)});
      else pass_cnt++;
    end
  endtask

  task automatic test_collision();
    set_read(39'(20 << 2), 2'd0, 2'd0);
    set_write(20, 0, 1'b1, 1'b0);
    #1;
    total_cnt++;
    if (bus.w_yumi_o !== 1'b0) $display("FAIL collide_noforce_yumi: got %b want 0", bus.w_yumi_o);
    else pass_cnt++;
    tick();
    idle();
    total_cnt++;
    if ({bus.pred_v_o, bus.idx_o, bus.val_o} !== {1'b1, 9'd20, 6'o33})
      $display("FAIL collide_noforce_read: got %h want %h", {bus.pred_v_o, bus.idx_o, bus.val_o}, {1'b1, 9'd20, 6'o33});
    else pass_cnt++;
    set_read(39'(21 << 2), 2'd0, 2'd0);
    tick();
    idle();
    set_read(39'(20 << 2), 2'd0, 2'd0);
    set_write(20, 0, 1'b1, 1'b1);
    #1;
    total_cnt++;
    if (bus.w_yumi_o !== 1'b1) $display("FAIL collide_force_yumi: got %b want 1", bus.w_yumi_o);
    else pass_cnt++;
    tick();
    idle();
    upd(20, 0, 1'b1);
    total_cnt++;
    if ({bus.pred_v_o, bus.idx_o} !== {1'b0, 9'd21})
      $display("FAIL collide_force_drop: got v %b idx %0d want v 0 idx 21", bus.pred_v_o, bus.idx_o);
    else pass_cnt++;
    set_read(39'(20 << 2), 2'd0, 2'd0);
    tick();
    idle();
    total_cnt++;
    if ({bus.pred_v_o, bus.idx_o, bus.val_o} !== {1'b1, 9'd20, 6'o34})
      $display("FAIL collide_force_after: got %h want %h", {bus.pred_v_o, bus.idx_o, bus.val_o}, {1'b1, 9'd20, 6'o34});
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int n;
    for (int k = 0; k < 4; k++) begin
      set_write(5, 0, 1'b1, 1'b0);
      tick();
      idle();
      upd(5, 0, 1'b1);
    end
    set_read(39'(5 << 2), 2'd0, 2'd0);
    flush = 1'b1;
    tick();
    idle();
    total_cnt++;
    if ({init_done, bus.pred_v_o, bus.val_o} !== {1'b0, 1'b1, 6'o37})
      $display("FAIL flush_cycle: got %h want %h", {init_done, bus.pred_v_o, bus.val_o}, {1'b0, 1'b1, 6'o37});
    else pass_cnt++;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      set_read(39'(5 << 2), 2'd0, 2'd0);
      set_write(5, 0, 1'b1, 1'b1);
      #1;
      total_cnt++;
      if (bus.w_yumi_o !== 1'b0) $display("FAIL clear_yumi_%0d: got %b want 0", k, bus.w_yumi_o);
      else pass_cnt++;
      tick();
      n++;
      idle();
      total_cnt++;
      if (bus.pred_v_o !== 1'b0) $display("FAIL clear_read_%0d: got %b want 0", k, bus.pred_v_o);
      else pass_cnt++;
    end
    while (!init_done && n < 2000) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n !== 512) $display("FAIL flush_clear_cycles: got %0d want 512", n);
    else pass_cnt++;
    clear_model();
    set_read(39'(5 << 2), 2'd0, 2'd0);
    tick();
    idle();
    total_cnt++;
    if ({bus.pred_v_o, bus.val_o} !== {1'b1, 6'o33})
      $display("FAIL flush_row5: got %h want %h", {bus.pred_v_o, bus.val_o}, {1'b1, 6'o33});
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [38:0] addr;
    logic [1:0] gh, md;
    logic rv, wv, tk, fc, col, wacc, racc, wo;
    int ri, wi, c;
    for (int k = 0; k < 400; k++) begin
      rv = k == 0 ? 1'b1 : 1'($urandom);
      wv = k == 0 ? 1'b0 : 1'($urandom);
      addr = {7'($urandom), $urandom};
      gh = 2'($urandom);
      md = 2'($urandom);
      ri = int'(exp_idx(addr, gh, md));
      wi = $urandom_range(0, 2) == 0 ? ri : int'($urandom_range(0, 511));
      wo = 1'($urandom);
      tk = 1'($urandom);
      fc = 1'($urandom);
      col = rv && wv && ri == wi;
      wacc = wv && !(col && !fc);
      racc = rv && !(col && fc);
      if (rv) set_read(addr, gh, md);
      if (wv) set_write(wi, int'(wo), tk, fc);
      #1;
      total_cnt++;
      if (bus.w_yumi_o !== wacc) $display("FAIL rand_yumi_%0d: got %b want %b", k, bus.w_yumi_o, wacc);
      else pass_cnt++;
      if (racc) begin
        c = mdl[ri][addr[11]];
        e_val = row_of(ri);
        e_pred = c >= 4;
        e_conf = c == 0 || c == 7;
        e_idx = 9'(ri);
        e_off = addr[11];
      end
      tick();
      idle();
      if (wacc) upd(wi, int'(wo), tk);
      total_cnt++;
      if ({bus.pred_v_o, bus.val_o, bus.pred_o, bus.conf_o, bus.idx_o, bus.offset_o} !==
          {racc, e_val, e_pred, e_conf, e_idx, e_off})
        $display("FAIL rand_read_%0d: got %h want %h", k,
                 {bus.pred_v_o, bus.val_o, bus.pred_o, bus.conf_o, bus.idx_o, bus.offset_o},
                 {racc, e_val, e_pred, e_conf, e_idx, e_off});
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    int n;
    set_read(39'h800 | 39'(7 << 2), 2'd0, 2'd0);
    tick();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 101; k++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total_cnt++;
    if ({init_done, bus.pred_v_o, bus.val_o, bus.pred_o, bus.conf_o, bus.idx_o, bus.offset_o} !== '0)
      $display("FAIL midreset_state: got %h want 0",
               {init_done, bus.pred_v_o, bus.val_o, bus.pred_o, bus.conf_o, bus.idx_o, bus.offset_o});
    else pass_cnt++;
    wait_init(n);
    total_cnt++;
    if (n !== 513) $display("FAIL midreset_init_cycles: got %0d want 513", n);
    else pass_cnt++;
    total_cnt++;
    if ({bus.pred_v_o, bus.val_o, bus.pred_o, bus.conf_o, bus.idx_o, bus.offset_o} !== '0)
      $display("FAIL midreset_outputs: got %h want 0",
               {bus.pred_v_o, bus.val_o, bus.pred_o, bus.conf_o, bus.idx_o, bus.offset_o});
    else pass_cnt++;
    clear_model();
    set_read(39'h800 | 39'(7 << 2), 2'd0, 2'd0);
    tick();
    idle();
    total_cnt++;
    if ({bus.pred_v_o, bus.val_o, bus.idx_o, bus.offset_o} !== {1'b1, 6'o33, 9'd7, 1'b1})
      $display("FAIL midreset_row7: got %h want %h", {bus.pred_v_o, bus.val_o, bus.idx_o, bus.offset_o},
               {1'b1, 6'o33, 9'd7, 1'b1});
    else pass_cnt++;
  endtask

  initial begin
    bus.r_addr_i = '0;
    bus.r_ghist_i = '0;
    bus.w_idx_i = '0;
    bus.w_offset_i = '0;
    bus.w_val_i = '0;
    idle();
    test_reset();
    test_init_read();
    test_modes();
    test_saturation();
    test_collision();
    test_flush();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
